// File: rtl/sonuc_bcd_donusturucu.sv
// sonuc_bcd_donusturucu: iterative double-dabble converter from the 64-bit
// calculator result to packed BCD digits, with significant-digit count and overflow path.
`default_nettype none

module sonuc_bcd_donusturucu #(
  parameter int GENISLIK = 64,
  parameter int BASAMAK  = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gecerli_in,
  input  logic [GENISLIK-1:0]    sonuc_in,
  input  logic                   tasma_in,
  output logic                   hazir,
  output logic [4*BASAMAK-1:0]   bcd_out,
  output logic [4:0]             basamak_sayisi,
  output logic                   tasma_out,
  output logic                   gecerli_out
);

  localparam int             SW       = $clog2(GENISLIK + 1);
  localparam logic [SW-1:0]  SON_ADIM = SW'(GENISLIK - 1);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    KAYDIR = 2'd1,
    BITTI  = 2'd2
  } durum_t;

  durum_t               durum_q;
  logic [GENISLIK-1:0]  ikili_q;
  logic [4*BASAMAK-1:0] bcd_q;
  logic [SW-1:0]        sayac_q;
  logic                 tasma_q;

  logic [4*BASAMAK-1:0] duzelt_d;
  logic [4*BASAMAK-1:0] bcd_d;
  logic [GENISLIK-1:0]  ikili_d;
  logic [4:0]           sayi_d;

  // One double-dabble step: add-3 on digits >= 5, then shift {bcd, binary} left.
  always_comb begin
    duzelt_d = bcd_q;
    for (int i = 0; i < BASAMAK; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        duzelt_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d   = {duzelt_d[4*BASAMAK-2:0], ikili_q[GENISLIK-1]};
    ikili_d = {ikili_q[GENISLIK-2:0], 1'b0};
  end

  // Highest non-zero digit decides the count; an all-zero result still shows one digit.
  always_comb begin
    sayi_d = 5'd1;
    for (int i = 0; i < BASAMAK; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        sayi_d = 5'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q        <= BOSTA;
      hazir          <= 1'b1;
      ikili_q        <= '0;
      bcd_q          <= '0;
      sayac_q        <= '0;
      tasma_q        <= 1'b0;
      bcd_out        <= '0;
      basamak_sayisi <= 5'd0;
      tasma_out      <= 1'b0;
      gecerli_out    <= 1'b0;
    end else begin
      gecerli_out <= 1'b0;
      case (durum_q)
        BOSTA: begin
          if (gecerli_in) begin
            ikili_q <= sonuc_in;
            tasma_q <= tasma_in;
            bcd_q   <= '0;
            sayac_q <= '0;
            hazir   <= 1'b0;
            durum_q <= tasma_in ? BITTI : KAYDIR;
          end
        end
        KAYDIR: begin
          bcd_q   <= bcd_d;
          ikili_q <= ikili_d;
          sayac_q <= sayac_q + 1'b1;
          if (sayac_q == SON_ADIM) begin
            durum_q <= BITTI;
          end
        end
        BITTI: begin
          gecerli_out <= 1'b1;
          hazir       <= 1'b1;
          durum_q     <= BOSTA;
          if (tasma_q) begin
            bcd_out        <= {BASAMAK{4'hF}};
            basamak_sayisi <= 5'd0;
            tasma_out      <= 1'b1;
          end else begin
            bcd_out        <= bcd_q;
            basamak_sayisi <= sayi_d;
            tasma_out      <= 1'b0;
          end
        end
        default: begin
          durum_q <= BOSTA;
          hazir   <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sonuc_bcd_donusturucu.sv
// Directed bench for sonuc_bcd_donusturucu: latency, digit values, overflow, reset abort, back-to-back.
`default_nettype none

module tb_sonuc_bcd_donusturucu;

  logic        clk;
  logic        rst;
  logic        gecerli_in;
  logic [63:0] sonuc_in;
  logic        tasma_in;
  logic        hazir;
  logic [79:0] bcd_out;
  logic [4:0]  basamak_sayisi;
  logic        tasma_out;
  logic        gecerli_out;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int low_cnt;
  int toggles;
  logic seen;

  sonuc_bcd_donusturucu #(.GENISLIK(64), .BASAMAK(20)) dut (
    .clk            (clk),
    .rst            (rst),
    .gecerli_in     (gecerli_in),
    .sonuc_in       (sonuc_in),
    .tasma_in       (tasma_in),
    .hazir          (hazir),
    .bcd_out        (bcd_out),
    .basamak_sayisi (basamak_sayisi),
    .tasma_out      (tasma_out),
    .gecerli_out    (gecerli_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a posedge; issues a request accepted at the next edge (E0).
  task automatic start(input logic [63:0] v, input logic t);
    sonuc_in   = v;
    tasma_in   = t;
    gecerli_in = 1'b1;
    @(posedge clk);
    #1;
    gecerli_in = 1'b0;
    low_cnt    = (hazir == 1'b0) ? 1 : 0;
  endtask

  // Counts edges until gecerli_out is seen; bounded so a dead DUT cannot hang the run.
  task automatic wait_pulse(output int l);
    l = 0;
    while (l < 200) begin
      @(posedge clk);
      #1;
      l++;
      if (gecerli_out === 1'b1) break;
      if (hazir === 1'b0) low_cnt++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    gecerli_in = 1'b0;
    sonuc_in   = '0;
    tasma_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hazir", 80'(hazir), 80'd1);
    chk("reset_bcd", bcd_out, 80'd0);
    chk("reset_cnt", 80'(basamak_sayisi), 80'd0);
    chk("reset_tasma", 80'(tasma_out), 80'd0);
    chk("reset_valid", 80'(gecerli_out), 80'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero result
    start(64'd0, 1'b0);
    wait_pulse(lat);
    chk("zero_latency", 80'(lat), 80'd65);
    chk("zero_hazir_low", 80'(low_cnt), 80'd65);
    chk("zero_bcd", bcd_out, 80'd0);
    chk("zero_cnt", 80'(basamak_sayisi), 80'd1);
    chk("zero_tasma", 80'(tasma_out), 80'd0);
    chk("zero_hazir_at_pulse", 80'(hazir), 80'd1);
    @(posedge clk);
    #1;
    chk("zero_pulse_width", 80'(gecerli_out), 80'd0);
    chk("zero_hold_cnt", 80'(basamak_sayisi), 80'd1);

    start(64'd12345, 1'b0);
    wait_pulse(lat);
    chk("d12345_latency", 80'(lat), 80'd65);
    chk("d12345_bcd", bcd_out, 80'h12345);
    chk("d12345_cnt", 80'(basamak_sayisi), 80'd5);

    start(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_pulse(lat);
    chk("max_bcd", bcd_out, 80'h18446744073709551615);
    chk("max_cnt", 80'(basamak_sayisi), 80'd20);

    start(64'h8AC7_2304_89E8_0000, 1'b0);
    wait_pulse(lat);
    chk("pow19_bcd", bcd_out, 80'h10000000000000000000);
    chk("pow19_cnt", 80'(basamak_sayisi), 80'd20);

    start(64'h8AC7_2304_89E7_FFFF, 1'b0);
    wait_pulse(lat);
    chk("nines19_bcd", bcd_out, 80'h09999999999999999999);
    chk("nines19_cnt", 80'(basamak_sayisi), 80'd19);

    // Overflow path bypasses the shift engine
    start(64'h0123_4567_89AB_CDEF, 1'b1);
    wait_pulse(lat);
    chk("ovf_latency", 80'(lat), 80'd1);
    chk("ovf_bcd", bcd_out, {20{4'hF}});
    chk("ovf_cnt", 80'(basamak_sayisi), 80'd0);
    chk("ovf_tasma", 80'(tasma_out), 80'd1);
    @(posedge clk);
    #1;

    // Reset in flight aborts the conversion
    start(64'd999, 1'b0);
    repeat (29) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_bcd", bcd_out, 80'd0);
    chk("abort_cnt", 80'(basamak_sayisi), 80'd0);
    chk("abort_tasma", 80'(tasma_out), 80'd0);
    chk("abort_hazir", 80'(hazir), 80'd1);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (gecerli_out === 1'b1) seen = 1'b1;
    end
    chk("abort_no_pulse", 80'(seen), 80'd0);
    start(64'd7, 1'b0);
    wait_pulse(lat);
    chk("seven_latency", 80'(lat), 80'd65);
    chk("seven_bcd", bcd_out, 80'h7);
    chk("seven_cnt", 80'(basamak_sayisi), 80'd1);

    // Busy-time requests ignored, then back-to-back on the pulse cycle
    @(posedge clk);
    #1;
    start(64'd42, 1'b0);
    toggles = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      toggles++;
      gecerli_in = toggles[0];
      sonuc_in   = 64'd5 + 64'(toggles);
      tasma_in   = toggles[1];
    end
    gecerli_in = 1'b0;
    tasma_in   = 1'b0;
    wait_pulse(lat);
    chk("busy_latency", 80'(lat + toggles), 80'd65);
    chk("busy_bcd", bcd_out, 80'h42);
    chk("busy_tasma", 80'(tasma_out), 80'd0);
    start(64'd77777, 1'b0);
    wait_pulse(lat);
    chk("b2b_latency", 80'(lat + 1), 80'd66);
    chk("b2b_bcd", bcd_out, 80'h77777);
    chk("b2b_cnt", 80'(basamak_sayisi), 80'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
